fetch_line_ctrl: RTL
====================

# fetch_line_ctrl

Fetch line controller that sits directly upstream of the instruction buffer. It keeps the architectural fetch PC and turns the buffer's `fetch_inst` refill request into one 64-byte line request to the memory arbiter. It then delivers the returned 512-bit line, tagged with its PC, to the buffer as a rising edge on `pc_index_ready`. It also handles redirects: it updates the PC, pulses `clear_ibuffer`, and discards any response still in flight.

## Interface
- `RESET_PC`, 48'h0000_8000_0000, fetch PC after reset; 4-byte aligned.
- `DRAIN_CYCLES`, 18, post-delivery cycles during which no new fetch is accepted (covers the 16 FIFO writes plus settle).
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_inst`  in  1  refill request from the instruction buffer; sampled as a level.
- `redirect_valid`  in  1  redirect from the backend.
- `redirect_pc`  in  48  redirect target; 4-byte aligned.
- `pc_index_valid`  out  1  line request to the arbiter.
- `pc_index`  out  48  line start address (byte address, 4-byte aligned).
- `pc_operation_done`  in  1  arbiter response strobe; data is valid in the same cycle.
- `arb_read_data`  in  512  returned line; instruction k is at bits [32k+31:32k].
- `pc_index_ready`  out  1  line-valid pulse to the instruction buffer.
- `pc_read_inst`  out  512  captured line.
- `pc`  out  48  PC of instruction 0 of the captured line.
- `clear_ibuffer`  out  1  one-cycle flush pulse.
- `can_fetch_inst`  out  1  gates refill requests in the instruction buffer.

## Operation
- Internal state: `fetch_pc` (48 bits) and an FSM with states IDLE, REQ, ABORT, HOLD, DRAIN.
- Reset values:
  - `fetch_pc` = RESET_PC.
  - FSM = IDLE, with the first-cycle flag set.
  - `pc_index_valid`, `pc_index_ready`, `clear_ibuffer` = 0.
  - `pc_index`, `pc`, `pc_read_inst` = 0.
  - `can_fetch_inst` = 1.
- IDLE:
  - The first cycle after entry ignores `fetch_inst`. This masks the stale value the buffer holds in its register.
  - On any later cycle with `fetch_inst`=1, go to REQ. Drive `pc_index` = `fetch_pc` and `pc_index_valid` = 1.
- REQ:
  - Hold `pc_index_valid` and `pc_index` stable until `pc_operation_done`.
  - On `pc_operation_done`: capture `arb_read_data` into `pc_read_inst` and `fetch_pc` into `pc`.
  - In the same update, set `fetch_pc` <= `fetch_pc` + 64 (mod 2^48), drop `pc_index_valid`, and go to HOLD.
- HOLD: `pc_index_ready` = 1 for exactly one cycle, then go to DRAIN.
- DRAIN: count DRAIN_CYCLES cycles, then go to IDLE.
- `can_fetch_inst` = 1 only while the FSM is in IDLE. It is a registered output: it is 1 in the cycle after the FSM enters IDLE.
- Redirect has priority over every other event:
  - `fetch_pc` <= `redirect_pc` and `clear_ibuffer` = 1 for the next cycle.
  - `pc_index_ready` is forced to 0 in the next cycle, including when the redirect arrives in HOLD.
  - Redirect in IDLE, HOLD or DRAIN: go to IDLE (first-cycle flag set).
  - Redirect in REQ without `pc_operation_done`: go to ABORT. Keep `pc_index_valid` and `pc_index` unchanged, because the arbiter handshake must complete.
  - Redirect in REQ together with `pc_operation_done`: discard the data and go to IDLE.
- ABORT:
  - Hold the request until `pc_operation_done`, then discard the data and go to IDLE.
  - A further redirect in ABORT updates `fetch_pc`, pulses `clear_ibuffer` again, and stays in ABORT.
- Data from a discarded response never reaches `pc_read_inst`, `pc` or `pc_index_ready`.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `fetch_inst` sampled in IDLE at cycle N -> `pc_index_valid`=1 at N+1.
- `pc_operation_done` at cycle M -> `pc_index_ready`=1, `pc`, `pc_read_inst` valid at M+1. `pc_index_ready` = 0 at M+2.
- `pc` and `pc_read_inst` hold their values until the next capture.
- Minimum line-to-line spacing: 1 (HOLD) + DRAIN_CYCLES + 1 (IDLE settle) + 1 (REQ) + arbiter latency.
- `redirect_valid` at cycle R -> `clear_ibuffer`=1 at R+1 only. `pc_index` equals `redirect_pc` on the first request issued after R.
- `reset` asserted mid-REQ: the request drops immediately (asynchronous). A `pc_operation_done` arriving after reset is ignored (IDLE).

## Test plan
- **Reset and first fetch.** Reset, then hold `fetch_inst`=1 -> `pc_index_valid` rises on the second cycle after reset release with `pc_index`=48'h8000_0000. `pc_operation_done` 5 cycles later with data D -> `pc_index_ready` pulses one cycle, `pc`=48'h8000_0000, `pc_read_inst`=D.
- **Sequential lines.** Three back-to-back fetches -> `pc_index` values 48'h8000_0000, 48'h8000_0040, 48'h8000_0080. `can_fetch_inst`=0 for at least 20 cycles after each `pc_index_ready`.
- **Redirect in DRAIN.** `redirect_pc`=48'h1234 -> `clear_ibuffer` pulses once. The next request carries `pc_index`=48'h1234.
- **Redirect in REQ, response 3 cycles later.** -> `pc_index_valid` stays high until `pc_operation_done`. No `pc_index_ready` for that response. The next request uses `redirect_pc`.
- **Wrap-around.** `redirect_pc`=48'hFFFF_FFFF_FFC0, then one line -> the next `pc_index`=0.
- **Asynchronous reset mid-REQ.** -> `pc_index_valid`=0 with no clock edge. A `pc_operation_done` after reset release produces no `pc_index_ready`.

Source files
------------

// File: rtl/fetch_line_ctrl.sv
// Fetch line controller: turns instruction-buffer refill requests into 64-byte line reads,
// delivers tagged lines and handles backend redirects, including ones that race a response.
module fetch_line_ctrl #(
  parameter logic [47:0] RESET_PC     = 48'h0000_8000_0000,
  parameter int unsigned DRAIN_CYCLES = 18
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         fetch_inst,
  input  logic         redirect_valid,
  input  logic [47:0]  redirect_pc,
  output logic         pc_index_valid,
  output logic [47:0]  pc_index,
  input  logic         pc_operation_done,
  input  logic [511:0] arb_read_data,
  output logic         pc_index_ready,
  output logic [511:0] pc_read_inst,
  output logic [47:0]  pc,
  output logic         clear_ibuffer,
  output logic         can_fetch_inst
);

  localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StReq, StAbort, StHold, StDrain} state_e;

  state_e          state_q;
  logic            first_q;
  logic [CntW-1:0] cnt_q;
  logic [47:0]     fetch_pc_q;
  logic            valid_q;
  logic [47:0]     pc_index_q;
  logic            ready_q;
  logic [511:0]    read_inst_q;
  logic [47:0]     pc_q;
  logic            clear_q;
  logic            can_fetch_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      first_q     <= 1'b1;
      cnt_q       <= '0;
      fetch_pc_q  <= RESET_PC;
      valid_q     <= 1'b0;
      pc_index_q  <= '0;
      ready_q     <= 1'b0;
      read_inst_q <= '0;
      pc_q        <= '0;
      clear_q     <= 1'b0;
      can_fetch_q <= 1'b1;
    end else begin
      clear_q     <= 1'b0;
      ready_q     <= 1'b0;
      can_fetch_q <= (state_q == StIdle);
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        clear_q    <= 1'b1;
        if (state_q == StReq || state_q == StAbort) begin
          // An outstanding arbiter handshake must finish before the request can drop.
          if (pc_operation_done) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
            first_q <= 1'b1;
          end else begin
            state_q <= StAbort;
          end
        end else begin
          state_q <= StIdle;
          first_q <= 1'b1;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            // First cycle in IDLE masks the stale fetch_inst held by the buffer.
            if (first_q) begin
              first_q <= 1'b0;
            end else if (fetch_inst) begin
              valid_q    <= 1'b1;
              pc_index_q <= fetch_pc_q;
              state_q    <= StReq;
            end
          end
          StReq: begin
            if (pc_operation_done) begin
              read_inst_q <= arb_read_data;
              pc_q        <= fetch_pc_q;
              fetch_pc_q  <= fetch_pc_q + 48'd64;
              valid_q     <= 1'b0;
              ready_q     <= 1'b1;
              state_q     <= StHold;
            end
          end
          StAbort: begin
            if (pc_operation_done) begin
              valid_q <= 1'b0;
              state_q <= StIdle;
              first_q <= 1'b1;
            end
          end
          StHold: begin
            cnt_q   <= '0;
            state_q <= StDrain;
          end
          StDrain: begin
            if (cnt_q == CntLast) begin
              state_q <= StIdle;
              first_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            first_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign pc_index_valid = valid_q;
  assign pc_index       = pc_index_q;
  assign pc_index_ready = ready_q;
  assign pc_read_inst   = read_inst_q;
  assign pc             = pc_q;
  assign clear_ibuffer  = clear_q;
  assign can_fetch_inst = can_fetch_q;

endmodule
